// File: rtl/control_unit.sv
// Control unit for a 5-bit-opcode accumulator machine: every instruction
// takes one FETCH cycle and one EXEC cycle against a synchronous instruction ROM.
module control_unit #(
    parameter int PC_WIDTH   = 11,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] instr,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   operand,
    output logic [1:0]            sel_a,
    output logic                  sel_b,
    output logic                  wr_acc,
    output logic                  op,
    output logic                  wr_ram,
    output logic                  rd_ram,
    output logic                  busy,
    output logic                  halted,
    output logic [15:0]           cycle_count
);

    localparam int OPC_WIDTH = DATA_WIDTH - PC_WIDTH;

    localparam logic [OPC_WIDTH-1:0] OPC_HLT  = OPC_WIDTH'(0);
    localparam logic [OPC_WIDTH-1:0] OPC_STO  = OPC_WIDTH'(1);
    localparam logic [OPC_WIDTH-1:0] OPC_LD   = OPC_WIDTH'(2);
    localparam logic [OPC_WIDTH-1:0] OPC_LDI  = OPC_WIDTH'(3);
    localparam logic [OPC_WIDTH-1:0] OPC_ADD  = OPC_WIDTH'(4);
    localparam logic [OPC_WIDTH-1:0] OPC_ADDI = OPC_WIDTH'(5);
    localparam logic [OPC_WIDTH-1:0] OPC_SUB  = OPC_WIDTH'(6);
    localparam logic [OPC_WIDTH-1:0] OPC_SUBI = OPC_WIDTH'(7);

    localparam logic [1:0] SEL_A_MEM = 2'b00;
    localparam logic [1:0] SEL_A_IMM = 2'b01;
    localparam logic [1:0] SEL_A_ALU = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALT
    } state_t;

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [15:0]          cnt_q, cnt_d;
    logic [15:0]          cnt_sat_inc;
    logic [OPC_WIDTH-1:0] opcode;

    assign opcode      = instr[DATA_WIDTH-1:PC_WIDTH];
    assign cnt_sat_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case statements can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        sel_a   = SEL_A_MEM;
        sel_b   = 1'b0;
        wr_acc  = 1'b0;
        op      = 1'b0;
        wr_ram  = 1'b0;
        rd_ram  = 1'b0;

        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d = S_FETCH;
                    pc_d    = '0;
                    cnt_d   = '0;
                end
            end

            S_FETCH: begin
                state_d = S_EXEC;
                cnt_d   = cnt_sat_inc;
            end

            S_EXEC: begin
                cnt_d = cnt_sat_inc;
                if (opcode == OPC_HLT) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_FETCH;
                    pc_d    = pc_q + PC_WIDTH'(1);
                end

                // Unlisted opcodes fall through with all controls low (NOP).
                case (opcode)
                    OPC_STO: begin
                        wr_ram = 1'b1;
                    end
                    OPC_LD: begin
                        rd_ram = 1'b1;
                        sel_a  = SEL_A_MEM;
                        wr_acc = 1'b1;
                    end
                    OPC_LDI: begin
                        sel_a  = SEL_A_IMM;
                        wr_acc = 1'b1;
                    end
                    OPC_ADD: begin
                        rd_ram = 1'b1;
                        sel_a  = SEL_A_ALU;
                        wr_acc = 1'b1;
                    end
                    OPC_ADDI: begin
                        sel_b  = 1'b1;
                        sel_a  = SEL_A_ALU;
                        wr_acc = 1'b1;
                    end
                    OPC_SUB: begin
                        rd_ram = 1'b1;
                        op     = 1'b1;
                        sel_a  = SEL_A_ALU;
                        wr_acc = 1'b1;
                    end
                    OPC_SUBI: begin
                        sel_b  = 1'b1;
                        op     = 1'b1;
                        sel_a  = SEL_A_ALU;
                        wr_acc = 1'b1;
                    end
                    default: begin
                    end
                endcase
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign pc          = pc_q;
    assign operand     = instr[PC_WIDTH-1:0];
    assign cycle_count = cnt_q;
    assign busy        = (state_q == S_FETCH) || (state_q == S_EXEC);
    assign halted      = (state_q == S_HALT);

endmodule
